// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg
//   Shared definitions for the load/store sequencer:
//   - mem_op_e      : memory operation codes driven by the execute stage
//   - SF_*          : store/access format codes presented to dmem
//   - mau_state_e   : sequencer state encoding
//   - helpers       : op classification, access format, alignment check
// ---------------------------------------------------------------------------
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4,
    SW  = 3'd5,
    SH  = 3'd6,
    SB  = 3'd7
  } mem_op_e;

  localparam logic [1:0] SF_WORD = 2'b00;
  localparam logic [1:0] SF_HALF = 2'b01;
  localparam logic [1:0] SF_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mau_state_e;

  function automatic logic is_store(mem_op_e op);
    return (op == SW) || (op == SH) || (op == SB);
  endfunction

  // Access width as seen by dmem; loads report their width too so the
  // byte-lane outputs describe the current access for either direction.
  function automatic logic [1:0] op_format(mem_op_e op);
    case (op)
      LW, SW:       return SF_WORD;
      LH, LHU, SH:  return SF_HALF;
      default:      return SF_BYTE;
    endcase
  endfunction

  // lsb is the low two bits of the offset from the dmem base.
  function automatic logic op_misaligned(mem_op_e op, logic [1:0] lsb);
    case (op_format(op))
      SF_WORD: return (lsb != 2'b00);
      SF_HALF: return lsb[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
//   Combinational lane select and sign/zero extension of a dmem read word.
//   Ports:
//     op     in   mem_op_e  load opcode (store codes pass data through)
//     pos    in   2         byte offset within the word
//     data   in   32        raw dmem read word
//     result out  32        right-justified, extended load value
// ---------------------------------------------------------------------------
module load_extend
  import mem_access_unit_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  pos,
  input  logic [31:0] data,
  output logic [31:0] result
);

  logic signed [15:0] half_lane;
  logic signed [7:0]  byte_lane;

  // Half-word loads are already known to be 2-byte aligned, so only pos[1]
  // chooses the lane.
  assign half_lane = pos[1] ? data[31:16] : data[15:0];

  always_comb begin
    byte_lane = data[7:0];
    case (pos)
      2'd0:    byte_lane = data[7:0];
      2'd1:    byte_lane = data[15:8];
      2'd2:    byte_lane = data[23:16];
      default: byte_lane = data[31:24];
    endcase
  end

  always_comb begin
    result = data;
    case (op)
      LH:      result = 32'(half_lane);
      LHU:     result = {16'h0000, half_lane};
      LB:      result = 32'(byte_lane);
      LBU:     result = {24'h00_0000, byte_lane};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Load/store sequencer between the execute stage and dmem. One byte-
//   addressed op is accepted per request, range/alignment checked, then
//   issued to dmem for exactly one cycle; loads are extracted and extended
//   into a registered result.
//   Ports:
//     clk                 in   1       rising-edge clock
//     rst_n               in   1       asynchronous active-low reset
//     req                 in   1       op request, sampled while ready=1
//     op                  in   3       mem_op_e code
//     addr                in   32      byte address
//     wdata               in   32      store data, right-justified
//     ready               out  1       idle, will accept req this cycle
//     done                out  1       one-cycle completion pulse
//     fault               out  1       with done: op rejected, no access
//     rdata               out  32      extended load result, held
//     dm_w / dm_r         out  1       dmem write / read enable
//     store_format_signal out  2       00 word, 01 half, 10 byte
//     detail_pos          out  2       byte offset within the word
//     dm_addr             out  ADDR_W  dmem word index
//     dm_wdata            out  32      latched store data, unmodified
//     dm_rdata            in   32      dmem read data (valid when dm_r=1)
// ---------------------------------------------------------------------------
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              fault,
  output logic [31:0]       rdata,
  output logic              dm_w,
  output logic              dm_r,
  output logic [1:0]        store_format_signal,
  output logic [1:0]        detail_pos,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata
);

  localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);

  mau_state_e        state_q;
  mem_op_e           op_q;
  logic [ADDR_W+1:0] off_q;
  logic [31:0]       wdata_q;
  logic              done_q;
  logic              fault_q;
  logic [31:0]       rdata_q;

  mem_op_e     op_in;
  logic [31:0] off;
  logic        illegal;
  logic [31:0] ext_data;

  assign op_in = mem_op_e'(op);

  // Unsigned subtraction: addresses below the base wrap to huge offsets and
  // fall out of range with the same compare.
  assign off     = addr - BASE_ADDR;
  assign illegal = (off >= SPAN_BYTES) || op_misaligned(op_in, off[1:0]);

  load_extend u_load_extend (
    .op     (op_q),
    .pos    (off_q[1:0]),
    .data   (dm_rdata),
    .result (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= LW;
      off_q   <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        // IDLE: latch the request; rejected ops skip straight to RESP
        ST_IDLE: begin
          done_q  <= 1'b0;
          fault_q <= 1'b0;
          if (req) begin
            op_q    <= op_in;
            off_q   <= off[ADDR_W+1:0];
            wdata_q <= wdata;
            if (illegal) begin
              state_q <= ST_RESP;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end else begin
              state_q <= ST_ACCESS;
            end
          end
        end
        // ACCESS: dmem commits stores on this edge; loads capture here too
        ST_ACCESS: begin
          if (!is_store(op_q)) begin
            rdata_q <= ext_data;
          end
          done_q  <= 1'b1;
          fault_q <= 1'b0;
          state_q <= ST_RESP;
        end
        // RESP: done/fault visible for this single cycle
        ST_RESP: begin
          done_q  <= 1'b0;
          fault_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          fault_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // ready is forced low while reset is asserted even though the state
  // register already reads IDLE.
  assign ready = rst_n && (state_q == ST_IDLE);
  assign done  = done_q;
  assign fault = fault_q;
  assign rdata = rdata_q;

  // Enables decode straight from state so an asynchronous reset during
  // ACCESS withdraws a pending store before the next edge.
  assign dm_w = (state_q == ST_ACCESS) &&  is_store(op_q);
  assign dm_r = (state_q == ST_ACCESS) && !is_store(op_q);

  assign store_format_signal = op_format(op_q);
  assign detail_pos          = off_q[1:0];
  assign dm_addr             = off_q[ADDR_W+1:2];
  assign dm_wdata            = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int          SPAN = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready, done, fault, dm_w, dm_r;
  logic [31:0] rdata, dm_wdata;
  logic [1:0]  store_format_signal, detail_pos;
  logic [10:0] dm_addr;
  wire  [31:0] dm_rdata;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req                 (req),
    .op                  (op),
    .addr                (addr),
    .wdata               (wdata),
    .ready               (ready),
    .done                (done),
    .fault               (fault),
    .rdata               (rdata),
    .dm_w                (dm_w),
    .dm_r                (dm_r),
    .store_format_signal (store_format_signal),
    .detail_pos          (detail_pos),
    .dm_addr             (dm_addr),
    .dm_wdata            (dm_wdata),
    .dm_rdata            (dm_rdata)
  );

  // dmem model: word array with byte-lane writes
  logic [31:0] dmem [2048];
  logic        mem_clr;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 2048; i++) dmem[i] <= '0;
    end else if (dm_w) begin
      case (store_format_signal)
        2'b00: dmem[dm_addr] <= dm_wdata;
        2'b01: begin
          if (detail_pos[1]) dmem[dm_addr][31:16] <= dm_wdata[15:0];
          else               dmem[dm_addr][15:0]  <= dm_wdata[15:0];
        end
        default: dmem[dm_addr][8*detail_pos +: 8] <= dm_wdata[7:0];
      endcase
    end
  end

  assign dm_rdata = dm_r ? dmem[dm_addr] : 32'hzzzz_zzzz;

  // Reference model: flat byte array addressed by offset from BASE
  logic [7:0]  ref_mem [SPAN];
  logic [31:0] ref_rdata;

  int errors = 0;
  int checks = 0;

  logic        last_f;
  logic [31:0] last_r;
  logic [1:0]  last_fmt, last_pos;
  logic [10:0] last_wa;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        fault;
    logic [31:0] rdata;
    logic [1:0]  fmt;
    logic [1:0]  pos;
    logic [10:0] wa;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic ref_illegal(logic [2:0] o, logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off >= 32'(SPAN)) return 1'b1;
    if ((o == SW || o == LW) && off[1:0] != 2'b00) return 1'b1;
    if ((o == SH || o == LH || o == LHU) && off[0]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic ref_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
    int unsigned off;
    off = a - BASE;
    if (ref_illegal(o, a)) return;
    case (o)
      SW: for (int b = 0; b < 4; b++) ref_mem[off+b] = d[8*b +: 8];
      SH: for (int b = 0; b < 2; b++) ref_mem[off+b] = d[8*b +: 8];
      SB: ref_mem[off] = d[7:0];
      LW: ref_rdata = {ref_mem[off+3], ref_mem[off+2], ref_mem[off+1], ref_mem[off]};
      LH: ref_rdata = {{16{ref_mem[off+1][7]}}, ref_mem[off+1], ref_mem[off]};
      LHU: ref_rdata = {16'h0, ref_mem[off+1], ref_mem[off]};
      LB: ref_rdata = {{24{ref_mem[off][7]}}, ref_mem[off]};
      default: ref_rdata = {24'h0, ref_mem[off]};
    endcase
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) chk({tag, " ready timeout"}, {31'h0, ready}, 32'h1);
  endtask

  // Issue one op and follow it until done; returns observed latency and
  // dmem enable counts. Called and returns on a negative edge.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output int nw, output int nr);
    wait_ready(tag);
    op = o; addr = a; wdata = d; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0; nw = 0; nr = 0;
    last_f = 1'b0; last_r = '0; last_fmt = '0; last_pos = '0; last_wa = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (dm_w) nw++;
      if (dm_r) nr++;
      if (dm_w || dm_r) begin
        last_fmt = store_format_signal;
        last_pos = detail_pos;
        last_wa  = dm_addr;
      end
      if (done) begin
        lat    = c;
        last_f = fault;
        last_r = rdata;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] d);
    int lat, nw, nr;
    logic exp_f, st;
    exp_f = ref_illegal(o, a);
    st    = (o == SW) || (o == SH) || (o == SB);
    ref_apply(o, a, d);
    do_op(tag, o, a, d, lat, nw, nr);
    chk({tag, " fault"},   {31'h0, last_f}, {31'h0, exp_f});
    chk({tag, " latency"}, lat, exp_f ? 1 : 2);
    chk({tag, " dm_w cycles"}, nw, (!exp_f && st) ? 1 : 0);
    chk({tag, " dm_r cycles"}, nr, (!exp_f && !st) ? 1 : 0);
    chk({tag, " rdata"}, last_r, ref_rdata);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, dn, prev, gap_bad, nw;
    logic [2:0]  ro;
    logic [31:0] ra;

    for (int i = 0; i < SPAN; i++) ref_mem[i] = 8'h00;
    ref_rdata = '0;
    rst_n = 1'b0; mem_clr = 1'b1; req = 1'b0; op = '0; addr = '0; wdata = '0;

    repeat (3) @(negedge clk);
    chk("reset ready", {31'h0, ready}, 32'h0);
    chk("reset done",  {31'h0, done},  32'h0);
    chk("reset fault", {31'h0, fault}, 32'h0);
    chk("reset dm_w",  {31'h0, dm_w},  32'h0);
    chk("reset dm_r",  {31'h0, dm_r},  32'h0);
    chk("reset rdata", rdata, 32'h0);
    mem_clr = 1'b0;
    rst_n = 1'b1;
    #1 chk("ready after reset", {31'h0, ready}, 32'h1);
    @(negedge clk);

    // op, addr, wdata, fault, rdata, format, detail_pos, dm_addr
    vecs.push_back('{SW,  32'h1001_0004, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 2'b00, 2'd0, 11'd1});
    vecs.push_back('{LW,  32'h1001_0004, 32'h0,         1'b0, 32'hDEAD_BEEF, 2'b00, 2'd0, 11'd1});
    vecs.push_back('{SB,  32'h1001_0009, 32'h0000_00A5, 1'b0, 32'hDEAD_BEEF, 2'b10, 2'd1, 11'd2});
    vecs.push_back('{LB,  32'h1001_0009, 32'h0,         1'b0, 32'hFFFF_FFA5, 2'b10, 2'd1, 11'd2});
    vecs.push_back('{LBU, 32'h1001_0009, 32'h0,         1'b0, 32'h0000_00A5, 2'b10, 2'd1, 11'd2});
    vecs.push_back('{SH,  32'h1001_000E, 32'h0000_8001, 1'b0, 32'h0000_00A5, 2'b01, 2'd2, 11'd3});
    vecs.push_back('{LH,  32'h1001_000E, 32'h0,         1'b0, 32'hFFFF_8001, 2'b01, 2'd2, 11'd3});
    vecs.push_back('{LHU, 32'h1001_000E, 32'h0,         1'b0, 32'h0000_8001, 2'b01, 2'd2, 11'd3});
    vecs.push_back('{LW,  32'h1001_0002, 32'h0,         1'b1, 32'h0000_8001, 2'b00, 2'd0, 11'd0});
    vecs.push_back('{LH,  32'h1001_0001, 32'h0,         1'b1, 32'h0000_8001, 2'b00, 2'd0, 11'd0});
    vecs.push_back('{LW,  32'h1000_FFFC, 32'h0,         1'b1, 32'h0000_8001, 2'b00, 2'd0, 11'd0});
    vecs.push_back('{SW,  32'h1001_1000, 32'h1234_5678, 1'b1, 32'h0000_8001, 2'b00, 2'd0, 11'd0});
    vecs.push_back('{SW,  32'h1001_0FFC, 32'h0BAD_F00D, 1'b0, 32'h0000_8001, 2'b00, 2'd0, 11'h3FF});
    vecs.push_back('{LW,  32'h1001_0FFC, 32'h0,         1'b0, 32'h0BAD_F00D, 2'b00, 2'd0, 11'h3FF});
    vecs.push_back('{LBU, 32'h1001_0FFF, 32'h0,         1'b0, 32'h0000_000B, 2'b10, 2'd3, 11'h3FF});
    vecs.push_back('{SW,  32'h1001_0010, 32'hCAFE_F00D, 1'b0, 32'h0000_000B, 2'b00, 2'd0, 11'd4});

    foreach (vecs[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      run_op(t, vecs[i].op, vecs[i].addr, vecs[i].wdata);
      chk({t, " fault tbl"}, {31'h0, last_f}, {31'h0, vecs[i].fault});
      chk({t, " rdata tbl"}, last_r, vecs[i].rdata);
      if (!vecs[i].fault) begin
        chk({t, " format"},     {30'h0, last_fmt}, {30'h0, vecs[i].fmt});
        chk({t, " detail_pos"}, {30'h0, last_pos}, {30'h0, vecs[i].pos});
        chk({t, " dm_addr"},    {21'h0, last_wa},  {21'h0, vecs[i].wa});
      end
    end

    // Reset during the ACCESS cycle of a store aborts it.
    wait_ready("rst abort");
    op = SW; addr = 32'h1001_0010; wdata = 32'h1234_5678; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    chk("abort dm_w in ACCESS", {31'h0, dm_w}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort dm_w drop",  {31'h0, dm_w},  32'h0);
    chk("abort dm_r",       {31'h0, dm_r},  32'h0);
    chk("abort done",       {31'h0, done},  32'h0);
    chk("abort fault",      {31'h0, fault}, 32'h0);
    chk("abort ready",      {31'h0, ready}, 32'h0);
    chk("abort rdata",      rdata, 32'h0);
    ref_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op("post-reset LW", LW, 32'h1001_0010, 32'h0);
    chk("post-reset LW value", last_r, 32'hCAFE_F00D);

    // req held high: one acceptance every three cycles.
    wait_ready("hold");
    op = LW; addr = 32'h1001_0004; wdata = '0; req = 1'b1;
    acc = 0; dn = 0; prev = -1; gap_bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (ready) begin
        acc++;
        if (prev >= 0 && c - prev != 3) gap_bad++;
        prev = c;
      end
      if (done) dn++;
      @(negedge clk);
    end
    req = 1'b0;
    ref_apply(LW, 32'h1001_0004, 32'h0);
    chk("hold accepts", acc, 4);
    chk("hold gap errors", gap_bad, 0);
    chk("hold done pulses", dn, 4);
    chk("hold rdata", rdata, ref_rdata);

    // req pulses during ACCESS/RESP must be dropped.
    wait_ready("drop");
    op = SB; addr = 32'h1001_0020; wdata = 32'h0000_0077; req = 1'b1;
    ref_apply(SB, 32'h1001_0020, 32'h0000_0077);
    @(posedge clk);
    #1 op = SW; addr = 32'h1001_0024; wdata = 32'hFFFF_FFFF;
    nw = 0;
    @(negedge clk);
    if (dm_w) nw++;
    @(negedge clk);
    if (dm_w) nw++;
    req = 1'b0;
    @(negedge clk);
    if (dm_w) nw++;
    chk("drop store count", nw, 1);
    run_op("drop LW", LW, 32'h1001_0024, 32'h0);
    run_op("drop LBU", LBU, 32'h1001_0020, 32'h0);

    // Randomized ops against the byte-array model.
    for (int i = 0; i < 150; i++) begin
      ro = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       ra = BASE + 32'(SPAN) + 32'($urandom_range(0, 15));
        1:       ra = BASE - 32'($urandom_range(1, 16));
        default: ra = BASE + 32'($urandom_range(0, 63));
      endcase
      run_op($sformatf("rnd%0d", i), ro, ra, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
